// File: rtl/serial_frame_loader.sv
// serial_frame_loader: debounces a bouncy load button, captures the switch word
// on each clean press and streams it out LSB-first with per-bit valid strobes
// and frame start/done markers for the downstream serial recognizer.
module serial_frame_loader #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int BIT_PERIOD      = 1
) (
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     load_btn,
   input  logic [WIDTH-1:0]         sw,
   output logic                     ser_bit,
   output logic                     ser_valid,
   output logic                     frame_start,
   output logic                     frame_done,
   output logic                     busy,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   localparam int IDX_W  = $clog2(WIDTH);
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int TICK_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_PERIOD - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic               sync_p0;
   logic               sync_p1;
   logic               btn_s;
   logic               deb;
   logic [CNT_W-1:0]   deb_cnt;
   logic               deb_d;
   logic               load_pulse;
   logic [WIDTH-1:0]   shreg;
   logic [TICK_W-1:0]  tick;
   logic [IDX_W-1:0]   idx_q;

   assign btn_s = sync_p1;

   // Two-flop synchronizer for the asynchronous button input
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= load_btn;
         sync_p1 <= sync_p0;
      end
   end

   // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         deb     <= 1'b0;
         deb_cnt <= '0;
      end else if (btn_s == deb) begin
         deb_cnt <= '0;
      end else if (deb_cnt == CNT_LAST) begin
         deb     <= btn_s;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   // Rising-edge detect on the debounced level, one registered pulse per press
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         deb_d      <= 1'b0;
         load_pulse <= 1'b0;
      end else begin
         deb_d      <= deb;
         load_pulse <= deb & ~deb_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic; presses outside IDLE are ignored, not queued
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_pulse) state_nxt = SHIFT;
         SHIFT:   if ((tick == TICK_LAST) && (idx_q == IDX_LAST)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Shift datapath: capture on press, then one shift per bit period
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         shreg <= '0;
         tick  <= '0;
         idx_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_pulse) begin
                  shreg <= sw;
                  tick  <= '0;
                  idx_q <= '0;
               end
            end
            SHIFT: begin
               if (tick == TICK_LAST) begin
                  tick  <= '0;
                  shreg <= shreg >> 1;
                  // the index parks at 0 after the last bit so it never exceeds WIDTH-1
                  if (idx_q == IDX_LAST) idx_q <= '0;
                  else                   idx_q <= idx_q + 1'b1;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // FSM output decode from registered state
   always_comb begin
      ser_bit     = 1'b0;
      ser_valid   = 1'b0;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      busy        = (state != IDLE);
      bit_idx     = idx_q;
      if (state == SHIFT) begin
         ser_bit     = shreg[0];
         ser_valid   = (tick == '0);
         frame_start = (tick == '0) && (idx_q == '0);
      end
      if (state == DONE) begin
         frame_done = 1'b1;
      end
   end

endmodule

// File: tb/tb_serial_frame_loader.sv
// Bench for serial_frame_loader: one instance at BIT_PERIOD=1 and one at
// BIT_PERIOD=4, expected bit streams pushed when stimulus is applied and
// popped against the observed valid strobes.
module tb_serial_frame_loader;

   logic        clk = 1'b0;
   logic        clr_n = 1'b0;
   logic        btn_a = 1'b0;
   logic        btn_b = 1'b0;
   logic [15:0] sw_a = '0;
   logic [15:0] sw_b = '0;

   logic       a_ser_bit, a_ser_valid, a_frame_start, a_frame_done, a_busy;
   logic [3:0] a_bit_idx;
   logic       b_ser_bit, b_ser_valid, b_frame_start, b_frame_done, b_busy;
   logic [3:0] b_bit_idx;

   serial_frame_loader #(.WIDTH(16), .DEBOUNCE_CYCLES(20), .BIT_PERIOD(1)) dut_a (
      .clk(clk), .clr_n(clr_n), .load_btn(btn_a), .sw(sw_a),
      .ser_bit(a_ser_bit), .ser_valid(a_ser_valid), .frame_start(a_frame_start),
      .frame_done(a_frame_done), .busy(a_busy), .bit_idx(a_bit_idx)
   );

   serial_frame_loader #(.WIDTH(16), .DEBOUNCE_CYCLES(20), .BIT_PERIOD(4)) dut_b (
      .clk(clk), .clr_n(clr_n), .load_btn(btn_b), .sw(sw_b),
      .ser_bit(b_ser_bit), .ser_valid(b_ser_valid), .frame_start(b_frame_start),
      .frame_done(b_frame_done), .busy(b_busy), .bit_idx(b_bit_idx)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cycle = 0;

   // observations and expectations for instance A
   bit obs_a[$];
   int oidx_a[$];
   bit ost_a[$];
   bit exp_a[$];
   int eidx_a[$];
   int nstart_a, ndone_a, busy_a, lastv_a, done_a, startc_a;

   // observations and expectations for instance B
   bit obs_b[$];
   bit exp_b[$];
   int vcyc_b[$];
   bit sbit_b[$];
   int nstart_b, ndone_b, done_b;

   bit e, o, os;
   int ei, oi;

   task automatic clear_obs();
      obs_a.delete(); oidx_a.delete(); ost_a.delete(); exp_a.delete(); eidx_a.delete();
      nstart_a = 0; ndone_a = 0; busy_a = 0; lastv_a = -1; done_a = -1; startc_a = -1;
      obs_b.delete(); exp_b.delete(); vcyc_b.delete(); sbit_b.delete();
      nstart_b = 0; ndone_b = 0; done_b = -1;
   endtask

   // advance one clock and record what both instances show, 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
      cycle++;
      if (a_ser_valid) begin
         obs_a.push_back(a_ser_bit);
         oidx_a.push_back(int'(a_bit_idx));
         ost_a.push_back(a_frame_start);
         lastv_a = cycle;
      end
      if (a_frame_start) begin
         nstart_a++;
         if (startc_a < 0) startc_a = cycle;
      end
      if (a_frame_done) begin
         ndone_a++;
         done_a = cycle;
      end
      if (a_busy) busy_a++;
      if (b_ser_valid) begin
         obs_b.push_back(b_ser_bit);
         vcyc_b.push_back(cycle);
      end
      if (b_frame_start) nstart_b++;
      if (b_frame_done) begin
         ndone_b++;
         done_b = cycle;
      end
      if (b_busy && !b_frame_done) sbit_b.push_back(b_ser_bit);
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic push_a(input logic [15:0] w, input int n);
      for (int k = 0; k < n; k++) begin
         exp_a.push_back(w[k]);
         eidx_a.push_back(k);
      end
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      run(3);
      tests++;
      if ({a_ser_bit, a_ser_valid, a_frame_start, a_frame_done, a_busy, a_bit_idx} !== 9'd0) begin
         fails++;
         $display("FAIL reset_a: outputs=%b, expected all 0",
                  {a_ser_bit, a_ser_valid, a_frame_start, a_frame_done, a_busy, a_bit_idx});
      end
      tests++;
      if ({b_ser_bit, b_ser_valid, b_frame_start, b_frame_done, b_busy, b_bit_idx} !== 9'd0) begin
         fails++;
         $display("FAIL reset_b: outputs=%b, expected all 0",
                  {b_ser_bit, b_ser_valid, b_frame_start, b_frame_done, b_busy, b_bit_idx});
      end
      clr_n = 1'b1;
      run(5);
   endtask

   task automatic test_defaults();
      clear_obs();
      sw_a = 16'hA5C3;
      push_a(16'hA5C3, 16);
      btn_a = 1'b1;
      run(30);
      btn_a = 1'b0;
      run(50);
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front(); ei = eidx_a.pop_front();
         tests++;
         if (obs_a.size() == 0) begin
            fails++; $display("FAIL defaults_bit%0d: got no bit, expected %0d", ei, e);
         end else begin
            o = obs_a.pop_front(); oi = oidx_a.pop_front(); os = ost_a.pop_front();
            if (o !== e || oi !== ei || os !== (ei == 0)) begin
               fails++;
               $display("FAIL defaults_bit%0d: got bit=%0d idx=%0d start=%0d, expected bit=%0d idx=%0d start=%0d",
                        ei, o, oi, os, e, ei, (ei == 0));
            end
         end
      end
      tests++;
      if (obs_a.size() != 0) begin
         fails++; $display("FAIL defaults_extra: got %0d extra bits, expected 0", obs_a.size());
      end
      tests++;
      if (ndone_a != 1 || done_a != lastv_a + 1) begin
         fails++;
         $display("FAIL defaults_done: got %0d pulses at cycle %0d, expected 1 at cycle %0d",
                  ndone_a, done_a, lastv_a + 1);
      end
      tests++;
      if (busy_a != 17) begin
         fails++; $display("FAIL defaults_busy: got %0d busy cycles, expected 17", busy_a);
      end
   endtask

   task automatic test_bounce();
      int cs;
      clear_obs();
      sw_a = 16'h1234;
      push_a(16'h1234, 16);
      for (int r = 0; r < 4; r++) begin
         btn_a = 1'b1; run(5);
         btn_a = 1'b0; run(3);
      end
      tests++;
      if (nstart_a != 0 || obs_a.size() != 0) begin
         fails++; $display("FAIL bounce_quiet: got %0d frames, expected 0", nstart_a);
      end
      cs = cycle;
      btn_a = 1'b1;
      run(25);
      tests++;
      if (startc_a < 0 || startc_a - cs < 1 || startc_a - cs > 24) begin
         fails++; $display("FAIL bounce_latency: got start at +%0d, expected within +1..+24", startc_a - cs);
      end
      btn_a = 1'b0;
      run(60);
      tests++;
      if (nstart_a != 1 || ndone_a != 1) begin
         fails++; $display("FAIL bounce_frames: got %0d starts %0d dones, expected 1 and 1", nstart_a, ndone_a);
      end
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front(); ei = eidx_a.pop_front();
         tests++;
         if (obs_a.size() == 0) begin
            fails++; $display("FAIL bounce_bit%0d: got no bit, expected %0d", ei, e);
         end else begin
            o = obs_a.pop_front(); oi = oidx_a.pop_front(); os = ost_a.pop_front();
            if (o !== e || oi !== ei || os !== (ei == 0)) begin
               fails++;
               $display("FAIL bounce_bit%0d: got bit=%0d idx=%0d start=%0d, expected bit=%0d idx=%0d start=%0d",
                        ei, o, oi, os, e, ei, (ei == 0));
            end
         end
      end
   endtask

   task automatic test_repress_midframe();
      int budget;
      clear_obs();
      sw_a = 16'h0001;
      push_a(16'h0001, 16);
      btn_a = 1'b1;
      budget = 0;
      while (!a_frame_start && budget < 60) begin cyc(); budget++; end
      tests++;
      if (!a_frame_start) begin
         fails++; $display("FAIL repress_start: got no frame_start within %0d cycles, expected one", budget);
      end
      run(4);
      btn_a = 1'b0;
      sw_a = 16'hFFFF;
      run(3);
      btn_a = 1'b1;
      run(40);
      tests++;
      if (nstart_a != 1) begin
         fails++; $display("FAIL repress_no_second: got %0d frames, expected 1", nstart_a);
      end
      btn_a = 1'b0;
      run(30);
      sw_a = 16'hFFFF;
      push_a(16'hFFFF, 16);
      btn_a = 1'b1;
      run(30);
      btn_a = 1'b0;
      run(40);
      tests++;
      if (nstart_a != 2 || ndone_a != 2) begin
         fails++; $display("FAIL repress_frames: got %0d starts %0d dones, expected 2 and 2", nstart_a, ndone_a);
      end
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front(); ei = eidx_a.pop_front();
         tests++;
         if (obs_a.size() == 0) begin
            fails++; $display("FAIL repress_bit%0d: got no bit, expected %0d", ei, e);
         end else begin
            o = obs_a.pop_front(); oi = oidx_a.pop_front(); os = ost_a.pop_front();
            if (o !== e || oi !== ei || os !== (ei == 0)) begin
               fails++;
               $display("FAIL repress_bit%0d: got bit=%0d idx=%0d start=%0d, expected bit=%0d idx=%0d start=%0d",
                        ei, o, oi, os, e, ei, (ei == 0));
            end
         end
      end
   endtask

   task automatic test_slow_period();
      int bad_gap, lead0, ones;
      bit seen1;
      clear_obs();
      sw_b = 16'h8000;
      for (int k = 0; k < 16; k++) exp_b.push_back(k == 15);
      btn_b = 1'b1;
      run(30);
      sw_b = 16'hFFFF;
      btn_b = 1'b0;
      run(30);
      btn_b = 1'b1;
      run(60);
      btn_b = 1'b0;
      run(40);
      tests++;
      if (nstart_b != 1 || ndone_b != 1) begin
         fails++; $display("FAIL slow_frames: got %0d starts %0d dones, expected 1 and 1", nstart_b, ndone_b);
      end
      tests++;
      if (vcyc_b.size() != 16) begin
         fails++; $display("FAIL slow_strobes: got %0d strobes, expected 16", vcyc_b.size());
      end
      bad_gap = 0;
      for (int k = 1; k < vcyc_b.size(); k++) if (vcyc_b[k] - vcyc_b[k-1] != 4) bad_gap++;
      tests++;
      if (bad_gap != 0) begin
         fails++; $display("FAIL slow_spacing: got %0d strobe gaps not equal to 4, expected 0", bad_gap);
      end
      lead0 = 0; ones = 0; seen1 = 1'b0;
      foreach (sbit_b[k]) begin
         if (sbit_b[k]) begin seen1 = 1'b1; ones++; end
         else if (!seen1) lead0++;
      end
      tests++;
      if (lead0 != 60 || ones != 4 || sbit_b.size() != 64) begin
         fails++;
         $display("FAIL slow_stream: got %0d zeros then %0d ones over %0d cycles, expected 60, 4, 64",
                  lead0, ones, sbit_b.size());
      end
      tests++;
      if (vcyc_b.size() == 0 || done_b - vcyc_b[0] != 64) begin
         fails++; $display("FAIL slow_done: got done at cycle %0d, expected 64 after first strobe", done_b);
      end
      while (exp_b.size() > 0) begin
         e = exp_b.pop_front();
         tests++;
         if (obs_b.size() == 0) begin
            fails++; $display("FAIL slow_bit: got no bit, expected %0d", e);
         end else begin
            o = obs_b.pop_front();
            if (o !== e) begin
               fails++; $display("FAIL slow_bit%0d: got %0d, expected %0d", 15 - exp_b.size(), o, e);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      int budget;
      clear_obs();
      sw_a = 16'hA5C3;
      push_a(16'hA5C3, 8);
      btn_a = 1'b1;
      budget = 0;
      while (!a_frame_start && budget < 60) begin cyc(); budget++; end
      tests++;
      if (!a_frame_start) begin
         fails++; $display("FAIL rstmid_start: got no frame_start within %0d cycles, expected one", budget);
      end
      run(7);
      clr_n = 1'b0;
      btn_a = 1'b0;
      cyc();
      tests++;
      if ({a_ser_bit, a_ser_valid, a_frame_start, a_frame_done, a_busy, a_bit_idx} !== 9'd0) begin
         fails++;
         $display("FAIL rstmid_outputs: outputs=%b, expected all 0",
                  {a_ser_bit, a_ser_valid, a_frame_start, a_frame_done, a_busy, a_bit_idx});
      end
      clr_n = 1'b1;
      run(40);
      tests++;
      if (ndone_a != 0 || obs_a.size() != 8) begin
         fails++; $display("FAIL rstmid_abort: got %0d dones and %0d bits, expected 0 and 8", ndone_a, obs_a.size());
      end
      push_a(16'hA5C3, 16);
      btn_a = 1'b1;
      run(30);
      btn_a = 1'b0;
      run(50);
      tests++;
      if (nstart_a != 2 || ndone_a != 1) begin
         fails++; $display("FAIL rstmid_frames: got %0d starts %0d dones, expected 2 and 1", nstart_a, ndone_a);
      end
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front(); ei = eidx_a.pop_front();
         tests++;
         if (obs_a.size() == 0) begin
            fails++; $display("FAIL rstmid_bit%0d: got no bit, expected %0d", ei, e);
         end else begin
            o = obs_a.pop_front(); oi = oidx_a.pop_front(); os = ost_a.pop_front();
            if (o !== e || oi !== ei || os !== (ei == 0)) begin
               fails++;
               $display("FAIL rstmid_bit%0d: got bit=%0d idx=%0d start=%0d, expected bit=%0d idx=%0d start=%0d",
                        ei, o, oi, os, e, ei, (ei == 0));
            end
         end
      end
   endtask

   task automatic test_held_button();
      clear_obs();
      sw_a = 16'h5A5A;
      push_a(16'h5A5A, 16);
      btn_a = 1'b1;
      run(200);
      btn_a = 1'b0;
      run(40);
      tests++;
      if (nstart_a != 1 || ndone_a != 1) begin
         fails++; $display("FAIL held_frames: got %0d starts %0d dones, expected 1 and 1", nstart_a, ndone_a);
      end
      while (exp_a.size() > 0) begin
         e = exp_a.pop_front(); ei = eidx_a.pop_front();
         tests++;
         if (obs_a.size() == 0) begin
            fails++; $display("FAIL held_bit%0d: got no bit, expected %0d", ei, e);
         end else begin
            o = obs_a.pop_front(); oi = oidx_a.pop_front(); os = ost_a.pop_front();
            if (o !== e || oi !== ei || os !== (ei == 0)) begin
               fails++;
               $display("FAIL held_bit%0d: got bit=%0d idx=%0d start=%0d, expected bit=%0d idx=%0d start=%0d",
                        ei, o, oi, os, e, ei, (ei == 0));
            end
         end
      end
      tests++;
      if (obs_a.size() != 0) begin
         fails++; $display("FAIL held_extra: got %0d extra bits, expected 0", obs_a.size());
      end
   endtask

   initial begin
      clear_obs();
      test_reset();
      test_defaults();
      test_bounce();
      test_repress_midframe();
      test_slow_period();
      test_reset_midframe();
      test_held_button();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
